// File: rtl/stat_delta_hist_pkg.sv
// Shared defaults, FSM state encoding and the ET-to-bin mapping for the delta-time histogram.
package stat_delta_hist_pkg;

  localparam int unsigned NBIN_DEF      = 16;
  localparam int unsigned BIN_SHIFT_DEF = 8;
  localparam int unsigned CNT_W_DEF     = 16;
  localparam int unsigned EV_W          = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_SWAP  = 2'd3
  } state_t;

  // Coarse ET bin; everything past the range lands in the last (overflow) bin.
  function automatic int unsigned bin_index(input logic [EV_W-1:0] et,
                                            input int unsigned shift,
                                            input int unsigned nbin);
    int unsigned b;
    b = 32'(et) >> shift;
    return (b >= nbin) ? nbin - 1 : b;
  endfunction

endpackage

// File: rtl/stat_delta_hist_bank.sv
// One histogram bank: NBIN saturating counters with bulk clear, single increment port,
// combinational read mux and a sticky saturation flag.
module stat_delta_hist_bank
  import stat_delta_hist_pkg::*;
#(
  parameter int unsigned NBIN  = NBIN_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  localparam int unsigned AW   = $clog2(NBIN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [AW-1:0]    idx,
  input  logic [AW-1:0]    rd_idx,
  output logic [CNT_W-1:0] rd_data_c,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt [NBIN];

  // Clear wins over increment so a freshly selected bank always starts empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NBIN); i++) cnt[i] <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      for (int i = 0; i < int'(NBIN); i++) cnt[i] <= '0;
      sat <= 1'b0;
    end else if (inc) begin
      if (cnt[idx] == CNT_MAX) sat <= 1'b1;
      else                     cnt[idx] <= cnt[idx] + CNT_W'(1);
    end
  end

  assign rd_data_c = cnt[rd_idx];

endmodule

// File: rtl/stat_delta_hist.sv
// Double-buffered per-spill histogram of stat_delta event ETs; one bank accumulates while
// software reads the other.
module stat_delta_hist
  import stat_delta_hist_pkg::*;
#(
  parameter int unsigned NBIN      = NBIN_DEF,
  parameter int unsigned BIN_SHIFT = BIN_SHIFT_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF,
  localparam int unsigned AW       = $clog2(NBIN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_live,
  input  logic [15:0]      ndelta,
  input  logic [15:0]      et_raw,
  input  logic             hist_rd_en,
  input  logic [AW-1:0]    hist_rd_addr,
  output logic [CNT_W-1:0] hist_rd_data,
  output logic             hist_rd_valid,
  output logic             hist_new,
  output logic             hist_ready,
  output logic [15:0]      spill_ndelta,
  output logic [15:0]      spill_cnt,
  output logic             hist_ovf
);

  state_t           state, state_nxt;
  logic [1:0]       drain_cnt;
  logic             swap_c, drain_ld_c;
  logic [15:0]      ndelta_d;
  logic             evt_c;
  logic             s1_vld;
  logic [AW-1:0]    s1_bin;
  logic             acc_sel;
  logic             frz_sel;
  logic [15:0]      acc_nev;
  logic [CNT_W-1:0] bank_rd [2];
  logic [1:0]       bank_sat;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (in_live) state_nxt = ST_ACCUM;
      ST_ACCUM: if (!in_live) state_nxt = ST_DRAIN;
      ST_DRAIN: if (drain_cnt == 2'd1) state_nxt = ST_SWAP;
      ST_SWAP:  state_nxt = in_live ? ST_ACCUM : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    swap_c     = 1'b0;
    drain_ld_c = 1'b0;
    if (state == ST_SWAP) swap_c = 1'b1;
    if (state == ST_ACCUM && !in_live) drain_ld_c = 1'b1;
  end

  // Two drain cycles let the last S1/S2 events land before the banks swap.
  always_ff @(posedge clk) begin
    if (!rst_n)                 drain_cnt <= 2'd0;
    else if (drain_ld_c)        drain_cnt <= 2'd2;
    else if (state == ST_DRAIN) drain_cnt <= drain_cnt - 2'd1;
  end

  assign evt_c   = in_live && (ndelta == 16'(ndelta_d + 16'd1));
  assign frz_sel = ~acc_sel;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ndelta_d <= '0;
      s1_vld   <= 1'b0;
      s1_bin   <= '0;
    end else begin
      ndelta_d <= ndelta;
      s1_vld   <= evt_c;
      s1_bin   <= AW'(bin_index(et_raw, BIN_SHIFT, NBIN));
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    stat_delta_hist_bank #(.NBIN(NBIN), .CNT_W(CNT_W)) u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (swap_c && (acc_sel != 1'(g))),
      .inc       (s1_vld && (acc_sel == 1'(g))),
      .idx       (s1_bin),
      .rd_idx    (hist_rd_addr),
      .rd_data_c (bank_rd[g]),
      .sat       (bank_sat[g])
    );
  end

  // Swap bookkeeping and frozen-bank readout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_sel       <= 1'b0;
      acc_nev       <= '0;
      hist_rd_data  <= '0;
      hist_rd_valid <= 1'b0;
      hist_new      <= 1'b0;
      hist_ready    <= 1'b0;
      spill_ndelta  <= '0;
      spill_cnt     <= '0;
      hist_ovf      <= 1'b0;
    end else begin
      hist_rd_valid <= hist_rd_en;
      if (hist_rd_en) hist_rd_data <= bank_rd[frz_sel];
      hist_new <= swap_c;
      if (swap_c) begin
        acc_sel      <= ~acc_sel;
        acc_nev      <= '0;
        spill_ndelta <= acc_nev;
        hist_ovf     <= bank_sat[acc_sel];
        spill_cnt    <= spill_cnt + 16'd1;
        hist_ready   <= 1'b1;
      end else if (s1_vld) begin
        acc_nev <= acc_nev + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_stat_delta_hist.sv
// Randomized bench for stat_delta_hist: a full-width and a 4-bit-counter instance share stimulus
// and are checked against a per-spill event-count model.
module tb_stat_delta_hist;

  logic        clk = 1'b0;
  logic        rst_n, in_live, hist_rd_en;
  logic [15:0] ndelta, et_raw;
  logic [3:0]  hist_rd_addr;

  logic [15:0] hist_rd_data, spill_ndelta, spill_cnt;
  logic        hist_rd_valid, hist_new, hist_ready, hist_ovf;
  logic [3:0]  s_rd_data;
  logic [15:0] s_spill_ndelta, s_spill_cnt;
  logic        s_rd_valid, s_new, s_ready, s_ovf;

  int unsigned n_tests = 0, n_fail = 0;

  int unsigned acc_cnt [16];
  int unsigned frz_cnt [16];
  int unsigned acc_nev_m = 0, frz_nev = 0, spills = 0;
  logic [15:0] prev_nd = 16'd0;

  always #5 clk = ~clk;

  stat_delta_hist u_dut (
    .clk(clk), .rst_n(rst_n), .in_live(in_live), .ndelta(ndelta), .et_raw(et_raw),
    .hist_rd_en(hist_rd_en), .hist_rd_addr(hist_rd_addr), .hist_rd_data(hist_rd_data),
    .hist_rd_valid(hist_rd_valid), .hist_new(hist_new), .hist_ready(hist_ready),
    .spill_ndelta(spill_ndelta), .spill_cnt(spill_cnt), .hist_ovf(hist_ovf)
  );

  stat_delta_hist #(.CNT_W(4)) u_small (
    .clk(clk), .rst_n(rst_n), .in_live(in_live), .ndelta(ndelta), .et_raw(et_raw),
    .hist_rd_en(hist_rd_en), .hist_rd_addr(hist_rd_addr), .hist_rd_data(s_rd_data),
    .hist_rd_valid(s_rd_valid), .hist_new(s_new), .hist_ready(s_ready),
    .spill_ndelta(s_spill_ndelta), .spill_cnt(s_spill_cnt), .hist_ovf(s_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned sat_at(input int unsigned v, input int unsigned mx);
    return (v > mx) ? mx : v;
  endfunction

  // Drive one cycle; model counts an event when live and ndelta advanced by exactly one.
  task automatic step(input logic live, input logic [15:0] nd, input logic [15:0] et);
    int unsigned b;
    in_live = live; ndelta = nd; et_raw = et;
    if (rst_n && live && nd == 16'(prev_nd + 16'd1)) begin
      b = int'(et) / 256;
      if (b > 15) b = 15;
      acc_cnt[b]++;
      acc_nev_m++;
    end
    prev_nd = nd;
    @(posedge clk); #1;
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) step(in_live, prev_nd, et_raw);
  endtask

  task automatic event_at(input logic [15:0] et);
    step(1'b1, 16'(prev_nd + 16'd1), et);
  endtask

  task automatic live_rise();
    step(1'b1, 16'd0, 16'($urandom));
    hold(3);
  endtask

  task automatic check_frozen();
    logic ovf_s, ovf_m;
    ovf_s = 1'b0; ovf_m = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (frz_cnt[i] > 15) ovf_s = 1'b1;
      if (frz_cnt[i] > 65535) ovf_m = 1'b1;
    end
    chk("spill_cnt", 32'(spill_cnt), 32'(16'(spills)));
    chk("spill_ndelta", 32'(spill_ndelta), 32'(16'(frz_nev)));
    chk("s_spill_ndelta", 32'(s_spill_ndelta), 32'(16'(frz_nev)));
    chk("hist_ready", 32'(hist_ready), 32'd1);
    chk("hist_ovf", 32'(hist_ovf), 32'(ovf_m));
    chk("s_hist_ovf", 32'(s_ovf), 32'(ovf_s));
    for (int a = 0; a < 16; a++) begin
      hist_rd_en = 1'b1; hist_rd_addr = 4'(a);
      hold(1);
      chk($sformatf("rd_valid[%0d]", a), 32'(hist_rd_valid), 32'd1);
      chk($sformatf("bin[%0d]", a), 32'(hist_rd_data), sat_at(frz_cnt[a], 65535));
      chk($sformatf("s_bin[%0d]", a), 32'(s_rd_data), sat_at(frz_cnt[a], 15));
    end
    hist_rd_en = 1'b0;
    hold(1);
    chk("rd_valid_drop", 32'(hist_rd_valid), 32'd0);
  endtask

  // End the spill, wait (bounded) for the freeze, then move the model's spill to frozen.
  // With pp set, a continuous read of bin 1 must show the old spill through the swap cycle.
  task automatic close_spill(input bit pp);
    bit got;
    int unsigned old1;
    got  = 1'b0;
    old1 = frz_cnt[1];
    for (int i = 0; i < 10 && !got; i++) begin
      step(1'b0, prev_nd, et_raw);
      if (hist_new) got = 1'b1;
      if (pp) chk("pp_hold", 32'(hist_rd_data), sat_at(old1, 65535));
    end
    chk("hist_new_seen", 32'(got), 32'd1);
    for (int i = 0; i < 16; i++) begin
      frz_cnt[i] = acc_cnt[i];
      acc_cnt[i] = 0;
    end
    frz_nev   = acc_nev_m;
    acc_nev_m = 0;
    spills++;
    hold(1);
    chk("hist_new_pulse", 32'(hist_new), 32'd0);
    if (pp) chk("pp_new", 32'(hist_rd_data), sat_at(frz_cnt[1], 65535));
    hist_rd_en = 1'b0;
    check_frozen();
  endtask

  task automatic rand_spill(input int cycles, input int max_ev);
    int ev;
    int unsigned r;
    logic [15:0] et;
    ev = 0;
    live_rise();
    for (int i = 0; i < cycles; i++) begin
      r  = $urandom_range(0, 9);
      et = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h0FFF));
      if (r < 5 && ev < max_ev) begin
        event_at(et);
        ev++;
      end else if (r == 5) begin
        step(1'b1, 16'(prev_nd + 16'($urandom_range(2, 6))), et);
      end else begin
        hold(1);
      end
    end
    close_spill(1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin acc_cnt[i] = 0; frz_cnt[i] = 0; end
    rst_n = 1'b0; in_live = 1'b0; ndelta = '0; et_raw = '0;
    hist_rd_en = 1'b0; hist_rd_addr = '0;
    #1;
    for (int i = 0; i < 5; i++) step(1'b0, 16'd0, 16'd0);
    chk("rst_rd_valid", 32'(hist_rd_valid), 32'd0);
    chk("rst_rd_data", 32'(hist_rd_data), 32'd0);
    chk("rst_new", 32'(hist_new), 32'd0);
    chk("rst_ready", 32'(hist_ready), 32'd0);
    chk("rst_spill_nd", 32'(spill_ndelta), 32'd0);
    chk("rst_spill_cnt", 32'(spill_cnt), 32'd0);
    chk("rst_ovf", 32'(hist_ovf), 32'd0);
    chk("rst_s_ovf", 32'(s_ovf), 32'd0);

    rst_n = 1'b1;
    hist_rd_en = 1'b1; hist_rd_addr = 4'd3;
    hold(1);
    chk("rst_rd3_valid", 32'(hist_rd_valid), 32'd1);
    chk("rst_rd3_data", 32'(hist_rd_data), 32'd0);
    hist_rd_en = 1'b0;
    hold(1);
    chk("rst_rd3_valid_drop", 32'(hist_rd_valid), 32'd0);

    // Basic spill: bins 1,2,1 over a ~100-cycle live window.
    live_rise();
    event_at(16'h0150); event_at(16'h0280); event_at(16'h01FF);
    hold(93);
    close_spill(1'b0);
    chk("t2_bin1_model", frz_cnt[1], 32'd2);

    // Overflow bin, bin-0 edge, and an event in the very last live cycle.
    live_rise();
    event_at(16'hFFFF); hold(2); event_at(16'h0FFF); event_at(16'h00FF);
    hold(4);
    event_at(16'h0300);
    close_spill(1'b0);

    // Back-to-back events to one bin saturate the 4-bit instance.
    live_rise();
    for (int i = 0; i < 20; i++) event_at(16'h0500);
    close_spill(1'b0);
    chk("sat_s_ovf", 32'(s_ovf), 32'd1);

    // Clean spill clears the overflow flag.
    rand_spill(30, 12);
    chk("clean_s_ovf", 32'(s_ovf), 32'd0);

    // Ping-pong: spill with bin1 events, then read bin1 continuously through spill 2.
    live_rise();
    for (int i = 0; i < 4; i++) event_at(16'h0100 + 16'(i));
    close_spill(1'b0);
    hist_rd_en = 1'b1; hist_rd_addr = 4'd1;
    step(1'b1, 16'd0, 16'h0100);
    for (int i = 0; i < 3; i++) begin
      hold(1);
      chk("pp_stable", 32'(hist_rd_data), sat_at(frz_cnt[1], 65535));
    end
    step(1'b1, 16'd5, 16'h0110);
    chk("pp_jump", 32'(hist_rd_data), sat_at(frz_cnt[1], 65535));
    for (int i = 0; i < 7; i++) begin
      event_at(16'h01A0);
      chk("pp_stable", 32'(hist_rd_data), sat_at(frz_cnt[1], 65535));
    end
    close_spill(1'b1);
    chk("pp_bin1_model", acc_nev_m + frz_cnt[1], 32'd7);

    for (int k = 0; k < 3; k++) rand_spill(int'($urandom_range(40, 120)), 1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
